fetch_stage: RTL and testbench

- IF stage of the 5-stage RV32I pipeline: holds PC, drives the word-addressed, combinational instruction memory, and registers the fetched word into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect from EX, hazard-unit stalls and decode flush.
- Output feeds the decode stage.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 19 +
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline constants and the IF/ID register payload type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int IMEM_DEPTH_DEFAULT = 1024;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            fault;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with reset/flush > stall > load priority
// Ports: clk, reset (sync, active-high), stall (hold), flush (load bubble), d (fetched payload), q (registered payload)
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0, fault: 1'b0};
  always_ff @(posedge clk) begin
    q <= (reset || flush) ? BUBBLE : stall ? q : d;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage holding the PC, addressing instruction memory and filling IF/ID
// Ports: clk, reset (sync, active-high); stall_f/stall_d/flush_d from the hazard unit;
// pc_src_e/pc_target_e redirect from EX; imem_addr/imem_rdata to a combinational memory;
// pc_f current fetch PC; instr_d/pc_d/pc_plus4_d/valid_d/fetch_fault_d IF/ID outputs to decode
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
  parameter int              IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            fetch_fault_d
);
  // One extra bit so the byte limit cannot overflow for large memories
  localparam logic [XLEN:0] FAULT_LIMIT = (XLEN+1)'(4 * IMEM_DEPTH);
  logic [XLEN-1:0] pc_plus4_f;
  if_id_t fetched, if_id;
  assign imem_addr = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;
  // Redirect beats stall_f so a resolved branch is never lost behind a hazard stall
  always_ff @(posedge clk) begin
    pc_f <= reset ? RESET_PC : pc_src_e ? {pc_target_e[XLEN-1:2], 2'b00} : stall_f ? pc_f : pc_plus4_f;
  end
  assign fetched = '{instr: imem_rdata, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1,
                     fault: ({1'b0, pc_f} >= FAULT_LIMIT)};
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall_d),
    .flush (flush_d),
    .d     (fetched),
    .q     (if_id)
  );
  assign instr_d = if_id.instr;
  assign pc_d = if_id.pc;
  assign pc_plus4_d = if_id.pc_plus4;
  assign valid_d = if_id.valid;
  assign fetch_fault_d = if_id.fault;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  typedef struct {
    logic        rst, sf, sd, fl, ps;
    logic [31:0] tgt, epc, einstr, epcd;
    logic        ev, ef;
  } vec_t;
  logic        clk = 0, reset = 1, stall_f = 0, stall_d = 0, flush_d = 0, pc_src_e = 0;
  logic [31:0] pc_target_e = 0;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_fault_d;
  logic [31:0] imem_addr_hi, imem_rdata_hi, pc_f_hi, instr_d_hi, pc_d_hi, pc_plus4_d_hi;
  logic        valid_d_hi, fetch_fault_d_hi;
  logic [31:0] mem [1024];
  vec_t tbl[$];
  vec_t sb[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[11:2]];
  assign imem_rdata_hi = mem[imem_addr_hi[11:2]];
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fetch_fault_d(fetch_fault_d)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
    .pc_f(pc_f_hi), .instr_d(instr_d_hi), .pc_d(pc_d_hi), .pc_plus4_d(pc_plus4_d_hi), .valid_d(valid_d_hi),
    .fetch_fault_d(fetch_fault_d_hi)
  );
  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
  endtask
  task automatic add(input logic rst, sf, sd, fl, ps, input logic [31:0] tgt, epc, ein, epd,
                     input logic ev, ef);
    vec_t v;
    v = '{rst: rst, sf: sf, sd: sd, fl: fl, ps: ps, tgt: tgt, epc: epc, einstr: ein, epcd: epd, ev: ev, ef: ef};
    tbl.push_back(v);
  endtask
  initial begin
    vec_t v, e;
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h0320_0513; mem[1] = 32'h01E0_0393; mem[2] = 32'h0073_0E33; mem[3] = 32'h4000_0113;
    mem[4] = 32'h0020_0193; mem[5] = 32'h0100_2883; mem[6] = 32'h0011_0233; mem[7] = 32'h0000_006F;
    mem[1022] = 32'hAAAA_0001; mem[1023] = 32'hBBBB_0002;
    //  rst sf sd fl ps  target        exp pc_f      exp instr_d   exp pc_d     v  f
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h13,       32'h0,       0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h03200513, 32'h0,       1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h8,         32'h01E00393, 32'h4,       1, 0);
    add(0, 1, 1, 0, 0, 32'h0,         32'h8,         32'h01E00393, 32'h4,       1, 0);
    add(0, 1, 1, 0, 0, 32'h0,         32'h8,         32'h01E00393, 32'h4,       1, 0);
    add(0, 1, 1, 0, 0, 32'h0,         32'h8,         32'h01E00393, 32'h4,       1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'hC,         32'h0073_0E33, 32'h8,      1, 0);
    add(0, 0, 0, 1, 1, 32'h14,        32'h14,        32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h18,        32'h01002883, 32'h14,      1, 0);
    add(0, 1, 0, 0, 1, 32'h1E,        32'h1C,        32'h0011_0233, 32'h18,     1, 0);
    add(0, 1, 1, 1, 0, 32'h0,         32'h1C,        32'h13,       32'h0,       0, 0);
    add(0, 0, 1, 0, 0, 32'h0,         32'h20,        32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h24,        32'hC0DE_0008, 32'h20,     1, 0);
    add(0, 0, 0, 1, 1, 32'hFF8,       32'hFF8,       32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'hFFC,       32'hAAAA_0001, 32'hFF8,    1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h1000,      32'hBBBB_0002, 32'hFFC,    1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h1004,      32'h03200513, 32'h1000,    1, 1);
    add(0, 0, 0, 1, 0, 32'h0,         32'h1008,      32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hBBBB_0002, 32'hFFFF_FFFC, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h03200513, 32'h0,       1, 0);
    add(1, 1, 1, 0, 1, 32'h40,        32'h0,         32'h13,       32'h0,       0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h03200513, 32'h0,       1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      reset = v.rst; stall_f = v.sf; stall_d = v.sd; flush_d = v.fl; pc_src_e = v.ps; pc_target_e = v.tgt;
      if (!v.rst && !v.ps) chk("imem_addr", i, imem_addr, pc_f);
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL step %0d scoreboard: got empty queue expected entry", i);
        continue;
      end
      e = sb.pop_front();
      chk("pc_f", i, pc_f, e.epc);
      chk("instr_d", i, instr_d, e.einstr);
      chk("pc_d", i, pc_d, e.epcd);
      chk("pc_plus4_d", i, pc_plus4_d, e.ev ? e.epcd + 32'd4 : 32'h0);
      chk("valid_d", i, 32'(valid_d), 32'(e.ev));
      chk("fetch_fault_d", i, 32'(fetch_fault_d), 32'(e.ef));
      if (i == 1) chk("hi reset pc_f", i, pc_f_hi, 32'hFFFF_FFFC);
      if (i == 2) begin
        chk("hi wrap pc_f", i, pc_f_hi, 32'h0);
        chk("hi instr_d", i, instr_d_hi, 32'hBBBB_0002);
        chk("hi pc_plus4_d", i, pc_plus4_d_hi, 32'h0);
        chk("hi fetch_fault_d", i, 32'(fetch_fault_d_hi), 32'h1);
      end
    end
    // Redirect with no flush: the wrong-path word fetched in the redirect cycle still enters IF/ID
    @(negedge clk);
    reset = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 1; pc_target_e = 32'h10;
    chk("no comb redirect path", 100, imem_addr, 32'h4);
    @(posedge clk); #1;
    chk("noflush pc_f", 100, pc_f, 32'h10);
    chk("noflush instr_d", 100, instr_d, 32'h01E00393);
    chk("noflush pc_d", 100, pc_d, 32'h4);
    @(negedge clk);
    pc_src_e = 0;
    @(posedge clk); #1;
    chk("after redirect instr_d", 101, instr_d, 32'h0020_0193);
    chk("after redirect pc_f", 101, pc_f, 32'h14);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
